// File: rtl/seven_segment_scan_if.sv
// seven_segment_scan_if: load/status/pin bundle for the seven-segment scan driver.
// master: drives value, load, hex_mode, dp_in; observes busy, overflow, seg, dp, an.
// slave:  the driver side (inverse directions).
interface seven_segment_scan_if #(
  parameter int DIGITS  = 4,
  parameter int VALUE_W = 16
);
  logic [VALUE_W-1:0] value;
  logic               load;
  logic               hex_mode;
  logic [DIGITS-1:0]  dp_in;
  logic               busy;
  logic               overflow;
  logic [6:0]         seg;
  logic               dp;
  logic [DIGITS-1:0]  an;
  modport master (output value, load, hex_mode, dp_in, input busy, overflow, seg, dp, an);
  modport slave (input value, load, hex_mode, dp_in, output busy, overflow, seg, dp, an);
endinterface

// File: rtl/seven_segment_scan.sv
// seven_segment_scan: multiplexed seven-segment driver with double-dabble BCD conversion or hex pass-through.
// Ports: clk; rst (synchronous, active-high); bus (slave modport) carrying value/load/hex_mode/dp_in
// inputs and busy/overflow/seg/dp/an outputs (seg/dp/an registered, inverted when ACTIVE_LOW=1).
// Optional feature: define SEVSEG_LZB_EN for leading-zero blanking.
module seven_segment_scan #(
  parameter int DIGITS      = 4,
  parameter int VALUE_W     = 16,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
)(
  input logic clk,
  input logic rst,
  seven_segment_scan_if.slave bus
);
  // ceil(VALUE_W*0.302)+1 nibbles always hold the full decimal value
  localparam int NB = (VALUE_W * 302 + 999) / 1000 + 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int CW = $clog2(VALUE_W + 1);
  localparam logic POL = ACTIVE_LOW != 0;
  localparam logic [0:0] IDLE = 1'b0, CONV = 1'b1;
  localparam logic [15:0][6:0] GLYPH = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [0:0]          state_q, state_d;
  logic [VALUE_W-1:0]  val_q, val_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*NB-1:0]     bcd_q, bcd_d, adj, nxt;
  logic [DIGITS-1:0]   dpc_q, dpc_d;
  logic [4*DIGITS-1:0] dig_q, dig_d;
  logic [DIGITS-1:0]   dpd_q, dpd_d;
  logic                ovf_q, ovf_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [3:0]          code;
  logic                blank;
  logic                tc;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NB; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    nxt = (4*NB)'({adj, val_q[VALUE_W-1]});
  end
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    dpc_d   = dpc_q;
    dig_d   = dig_q;
    dpd_d   = dpd_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE) begin
      if (bus.load && bus.hex_mode) begin
        dig_d = (4*DIGITS)'(bus.value);
        dpd_d = bus.dp_in;
        ovf_d = |(bus.value >> (4*DIGITS));
      end else if (bus.load) begin
        state_d = CONV;
        val_d   = bus.value;
        cnt_d   = '0;
        bcd_d   = '0;
        dpc_d   = bus.dp_in;
      end
    end else begin
      bcd_d = nxt;
      val_d = val_q << 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(VALUE_W - 1)) begin
        state_d = IDLE;
        dig_d   = (4*DIGITS)'(nxt);
        dpd_d   = dpc_q;
        ovf_d   = |(nxt >> (4*DIGITS));
      end
    end
  end
  assign tc    = pre_q == PW'(REFRESH_DIV - 1);
  assign pre_d = tc ? '0 : pre_q + 1'b1;
  assign idx_d = !tc ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
  assign code  = dig_q[{idx_q, 2'b00} +: 4];
`ifdef SEVSEG_LZB_EN
  // blank when this digit and every digit above it are zero; digit 0 always shows
  assign blank = idx_q != '0 && (dig_q >> {idx_q, 2'b00}) == '0;
`else
  assign blank = 1'b0;
`endif
  always_comb begin
    seg_d = {7{POL}} ^ (ovf_q ? 7'h40 : blank ? 7'h00 : GLYPH[code]);
    dp_d  = POL ^ (dpd_q[idx_q] & ~ovf_q & ~blank);
    an_d  = {DIGITS{POL}} ^ (DIGITS'(1) << idx_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      dpc_q   <= '0;
      dig_q   <= '0;
      dpd_q   <= '0;
      ovf_q   <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      seg_q   <= {7{POL}};
      dp_q    <= POL;
      an_q    <= {DIGITS{POL}};
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      dpc_q   <= dpc_d;
      dig_q   <= dig_d;
      dpd_q   <= dpd_d;
      ovf_q   <= ovf_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end
  assign bus.busy     = state_q == CONV;
  assign bus.overflow = ovf_q;
  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;
  assign bus.an       = an_q;
endmodule

// File: tb/tb_seven_segment_scan.sv
// tb_seven_segment_scan: directed self-checking bench for seven_segment_scan (DIGITS=4, REFRESH_DIV=4, active-low pins).
module tb_seven_segment_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [6:0] seg_f [4];
  logic       dp_f [4];
  logic       an_bad;
  // active-low segment codes for 0..F
  localparam logic [6:0] S [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [6:0] DASH  = 7'h3F;
  localparam logic [6:0] BLANK = 7'h7F;
`ifdef SEVSEG_LZB_EN
  localparam logic LZB = 1'b1;
`else
  localparam logic LZB = 1'b0;
`endif
  localparam logic [6:0] LZ = LZB ? BLANK : 7'h40;
  seven_segment_scan_if #(.DIGITS(4), .VALUE_W(16)) bus();
  seven_segment_scan #(.DIGITS(4), .VALUE_W(16), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic capture_frame();
    an_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seg_f[i] = 'x;
      dp_f[i]  = 1'bx;
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      case (bus.an)
        4'b1110: begin seg_f[0] = bus.seg; dp_f[0] = bus.dp; end
        4'b1101: begin seg_f[1] = bus.seg; dp_f[1] = bus.dp; end
        4'b1011: begin seg_f[2] = bus.seg; dp_f[2] = bus.dp; end
        4'b0111: begin seg_f[3] = bus.seg; dp_f[3] = bus.dp; end
        default: an_bad = 1'b1;
      endcase
    end
  endtask
  task automatic dec_load(input logic [15:0] v, input logic [3:0] d, output int n);
    @(negedge clk);
    bus.value = v; bus.hex_mode = 1'b0; bus.dp_in = d; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL rst_seg got %h exp 7f", bus.seg); end
    checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL rst_an got %b exp 1111", bus.an); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL rst_dp got %b exp 1", bus.dp); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", bus.overflow); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("FAIL rel_an got %b exp 1110", bus.an); end
    checks++; if (bus.seg !== 7'b1000000) begin errors++; $display("FAIL rel_seg got %b exp 1000000", bus.seg); end
    repeat (3) @(negedge clk);
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("FAIL scan_hold got %b exp 1110", bus.an); end
    @(negedge clk);
    checks++; if (bus.an !== 4'b1101) begin errors++; $display("FAIL scan_step got %b exp 1101", bus.an); end
  endtask
  task automatic test_decimal();
    int n;
    logic [6:0] e [4];
    dec_load(16'd1234, 4'b0000, n);
    checks++; if (n !== 16) begin errors++; $display("FAIL dec_busy_cycles got %0d exp 16", n); end
    capture_frame();
    e = '{S[4], S[3], S[2], S[1]};
    checks++; if (an_bad !== 1'b0) begin errors++; $display("FAIL dec_an_onehot got %b exp 0", an_bad); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (seg_f[i] !== e[i]) begin errors++; $display("FAIL dec_seg%0d got %b exp %b", i, seg_f[i], e[i]); end
      checks++; if (dp_f[i] !== 1'b1) begin errors++; $display("FAIL dec_dp%0d got %b exp 1", i, dp_f[i]); end
    end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL dec_ovf got %b exp 0", bus.overflow); end
  endtask
  task automatic test_hex();
    logic saw_busy;
    logic [6:0] e [4];
    @(negedge clk);
    bus.value = 16'hBEEF; bus.hex_mode = 1'b1; bus.dp_in = 4'b0100; bus.load = 1'b1;
    saw_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.load = 1'b0;
      saw_busy |= bus.busy;
    end
    checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL hex_busy got %b exp 0", saw_busy); end
    capture_frame();
    e = '{S[15], S[14], S[14], S[11]};
    for (int i = 0; i < 4; i++) begin
      checks++; if (seg_f[i] !== e[i]) begin errors++; $display("FAIL hex_seg%0d got %b exp %b", i, seg_f[i], e[i]); end
      checks++; if (dp_f[i] !== (i != 2)) begin errors++; $display("FAIL hex_dp%0d got %b exp %b", i, dp_f[i], i != 2); end
    end
    bus.hex_mode = 1'b0;
  endtask
  task automatic test_overflow();
    int n;
    logic [6:0] e [4];
    dec_load(16'd12345, 4'b1111, n);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bus.overflow); end
    capture_frame();
    for (int i = 0; i < 4; i++) begin
      checks++; if (seg_f[i] !== DASH) begin errors++; $display("FAIL ovf_seg%0d got %b exp %b", i, seg_f[i], DASH); end
      checks++; if (dp_f[i] !== 1'b1) begin errors++; $display("FAIL ovf_dp%0d got %b exp 1", i, dp_f[i]); end
    end
    dec_load(16'd99, 4'b0000, n);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", bus.overflow); end
    capture_frame();
    e = '{S[9], S[9], LZ, LZ};
    for (int i = 0; i < 4; i++) begin
      checks++; if (seg_f[i] !== e[i]) begin errors++; $display("FAIL d99_seg%0d got %b exp %b", i, seg_f[i], e[i]); end
    end
  endtask
  task automatic test_ignored_load();
    int n;
    logic [6:0] e [4];
    @(negedge clk);
    bus.value = 16'd500; bus.hex_mode = 1'b0; bus.dp_in = 4'b0000; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.value = 16'd7; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 13) begin errors++; $display("FAIL ign_busy_tail got %0d exp 13", n); end
    capture_frame();
    e = '{S[0], S[0], S[5], LZ};
    for (int i = 0; i < 4; i++) begin
      checks++; if (seg_f[i] !== e[i]) begin errors++; $display("FAIL ign_seg%0d got %b exp %b", i, seg_f[i], e[i]); end
    end
  endtask
  task automatic test_back_to_back();
    @(negedge clk);
    bus.value = 16'd321; bus.hex_mode = 1'b0; bus.dp_in = 4'b0000; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_last_busy got %b exp 1", bus.busy); end
    bus.value = 16'd7; bus.load = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_reject got %b exp 0", bus.busy); end
    bus.value = 16'd8;
    @(negedge clk);
    bus.load = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", bus.busy); end
    while (bus.busy) @(negedge clk);
    capture_frame();
    checks++; if (seg_f[0] !== S[8]) begin errors++; $display("FAIL b2b_seg0 got %b exp %b", seg_f[0], S[8]); end
    checks++; if (seg_f[1] !== LZ) begin errors++; $display("FAIL b2b_seg1 got %b exp %b", seg_f[1], LZ); end
  endtask
  task automatic test_reset_abort();
    @(negedge clk);
    bus.value = 16'd999; bus.hex_mode = 1'b0; bus.dp_in = 4'b1111; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
    repeat (20) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b exp 0", bus.busy); end
    capture_frame();
    for (int i = 0; i < 4; i++) begin
      checks++; if (seg_f[i] !== (i == 0 ? S[0] : LZ)) begin errors++; $display("FAIL abort_seg%0d got %b exp %b", i, seg_f[i], i == 0 ? S[0] : LZ); end
      checks++; if (dp_f[i] !== 1'b1) begin errors++; $display("FAIL abort_dp%0d got %b exp 1", i, dp_f[i]); end
    end
  endtask
  task automatic test_blanking();
    int n;
    logic [6:0] e [4];
    dec_load(16'd42, 4'b1000, n);
    capture_frame();
    e = '{S[2], S[4], LZ, LZ};
    for (int i = 0; i < 4; i++) begin
      checks++; if (seg_f[i] !== e[i]) begin errors++; $display("FAIL lzb42_seg%0d got %b exp %b", i, seg_f[i], e[i]); end
    end
    checks++; if (dp_f[3] !== LZB) begin errors++; $display("FAIL lzb42_dp3 got %b exp %b", dp_f[3], LZB); end
    dec_load(16'd0, 4'b0000, n);
    capture_frame();
    for (int i = 0; i < 4; i++) begin
      checks++; if (seg_f[i] !== (i == 0 ? S[0] : LZ)) begin errors++; $display("FAIL lzb0_seg%0d got %b exp %b", i, seg_f[i], i == 0 ? S[0] : LZ); end
    end
  endtask
  initial begin
    bus.value = '0;
    bus.load = 1'b0;
    bus.hex_mode = 1'b0;
    bus.dp_in = '0;
    test_reset();
    test_decimal();
    test_hex();
    test_overflow();
    test_ignored_load();
    test_back_to_back();
    test_reset_abort();
    test_blanking();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
